dynamic_range_sequencer: RTL and testbench

Hardware sequencer for the IIR filter's dynamic-range characterization. It sweeps the sine generator's amplitude control through a fixed number of linear steps and flushes the filter between steps. After each step's settle window it measures the filter output's peak magnitude and overflow over a measurement window, then reports one result per step. It sits between the sine/noise stimulus path and `iir_filter`, and replaces bench-driven amplitude stepping with a synthesizable controller.

---
 rtl/dynamic_range_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_dynamic_range_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_range_sequencer.sv
// Amplitude-sweep sequencer for IIR dynamic-range characterization: flush, settle, measure peak |data_out|.
// Optional macro DRS_OVF_HALT_EN: a step that reports overflow ends the sweep early.
module dynamic_range_sequencer #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned OUT_WIDTH       = 32,
  parameter int unsigned AMPLITUDE_STEPS = 10,
  parameter int unsigned AMP_MAX         = 65535,
  parameter int unsigned SETTLE_SAMPLES  = 256,
  parameter int unsigned MEASURE_SAMPLES = 1024,
  parameter logic [OUT_WIDTH-1:0] OVF_THRESH = OUT_WIDTH'(32'h3FFFFFFF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        sample_en,
  input  logic signed [OUT_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0]       amplitude,
  output logic                        filt_flush,
  output logic                        busy,
  output logic                        done,
  output logic                        peak_valid,
  output logic [7:0]                  step_idx,
  output logic [OUT_WIDTH-1:0]        peak_abs,
  output logic                        step_ovf,
  output logic                        overflow_flag
);

  localparam int unsigned STEP_SIZE = AMP_MAX / AMPLITUDE_STEPS;
  localparam int unsigned CNT_MAX   = (SETTLE_SAMPLES > MEASURE_SAMPLES) ? SETTLE_SAMPLES : MEASURE_SAMPLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned PROD_W    = DATA_WIDTH + 8;
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  MEASURE_LAST = CNT_W'(MEASURE_SAMPLES - 1);
  localparam logic [7:0]        LAST_STEP    = 8'(AMPLITUDE_STEPS - 1);
  localparam logic [PROD_W-1:0] STEP_EXT     = PROD_W'(STEP_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_REPORT  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                state_r, state_next_s;
  logic [1:0]            flush_cnt_r;
  logic [CNT_W-1:0]      sample_cnt_r;
  logic [OUT_WIDTH-1:0]  mag_s, peak_upd_s, peak_acc_r;
  logic                  ovf_upd_s, ovf_acc_r;
  logic [PROD_W-1:0]     amp_prod_s;
  logic                  halt_s, start_go_s, enter_report_s;

  logic [DATA_WIDTH-1:0] amplitude_r, amplitude_next_s;
  logic                  filt_flush_r, filt_flush_next_s;
  logic                  busy_r, busy_next_s;
  logic                  done_r, done_next_s;
  logic                  peak_valid_r, peak_valid_next_s;
  logic [7:0]            step_idx_r, step_idx_next_s;
  logic [OUT_WIDTH-1:0]  peak_abs_r, peak_abs_next_s;
  logic                  step_ovf_r, step_ovf_next_s;
  logic                  overflow_flag_r, overflow_flag_next_s;

`ifdef DRS_OVF_HALT_EN
  assign halt_s = step_ovf_r;
`else
  assign halt_s = 1'b0;
`endif

  assign amp_prod_s     = PROD_W'(step_idx_r) * STEP_EXT;
  assign start_go_s     = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (state_next_s == ST_FLUSH);
  assign enter_report_s = (state_r == ST_MEASURE) && (state_next_s == ST_REPORT);

  // Magnitude of the filter output; the most negative code maps to its own bit pattern
  always_comb begin
    if (data_out[OUT_WIDTH-1]) begin
      mag_s = $unsigned(-data_out);
    end else begin
      mag_s = $unsigned(data_out);
    end
  end

  // Peak/overflow accumulator update for the current strobe
  always_comb begin
    peak_upd_s = peak_acc_r;
    ovf_upd_s  = ovf_acc_r;
    if (sample_en) begin
      if (mag_s > peak_acc_r) begin
        peak_upd_s = mag_s;
      end else begin
        peak_upd_s = peak_acc_r;
      end
      ovf_upd_s = ovf_acc_r | (mag_s > OVF_THRESH);
    end else begin
      peak_upd_s = peak_acc_r;
      ovf_upd_s  = ovf_acc_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort overrides every other condition
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) state_next_s = ST_FLUSH;
          else       state_next_s = state_r;
        end
        ST_FLUSH: begin
          if (flush_cnt_r == 2'd3) state_next_s = ST_SETTLE;
          else                     state_next_s = ST_FLUSH;
        end
        ST_SETTLE: begin
          if (sample_en && (sample_cnt_r == SETTLE_LAST)) state_next_s = ST_MEASURE;
          else                                            state_next_s = ST_SETTLE;
        end
        ST_MEASURE: begin
          if (sample_en && (sample_cnt_r == MEASURE_LAST)) state_next_s = ST_REPORT;
          else                                             state_next_s = ST_MEASURE;
        end
        ST_REPORT: begin
          if ((step_idx_r == LAST_STEP) || halt_s) state_next_s = ST_DONE;
          else                                     state_next_s = ST_FLUSH;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output decode, computed from the next state so the registered outputs align with the state
  always_comb begin
    busy_next_s       = 1'b0;
    filt_flush_next_s = 1'b0;
    done_next_s       = 1'b0;
    peak_valid_next_s = 1'b0;
    case (state_next_s)
      ST_FLUSH:              begin busy_next_s = 1'b1; filt_flush_next_s = 1'b1; end
      ST_SETTLE, ST_MEASURE: begin busy_next_s = 1'b1; end
      ST_REPORT:             begin busy_next_s = 1'b1; peak_valid_next_s = 1'b1; end
      ST_DONE:               begin done_next_s = 1'b1; end
      default:               begin busy_next_s = 1'b0; end
    endcase

    if ((state_r == ST_FLUSH) && (state_next_s == ST_SETTLE)) begin
      amplitude_next_s = amp_prod_s[DATA_WIDTH-1:0];
    end else if ((state_next_s == ST_SETTLE) || (state_next_s == ST_MEASURE) || (state_next_s == ST_REPORT)) begin
      amplitude_next_s = amplitude_r;
    end else begin
      amplitude_next_s = {DATA_WIDTH{1'b0}};
    end

    if (start_go_s) begin
      step_idx_next_s = 8'd0;
    end else if ((state_r == ST_REPORT) && (state_next_s == ST_FLUSH)) begin
      step_idx_next_s = step_idx_r + 8'd1;
    end else begin
      step_idx_next_s = step_idx_r;
    end

    if (enter_report_s) begin
      peak_abs_next_s = peak_upd_s;
      step_ovf_next_s = ovf_upd_s;
    end else begin
      peak_abs_next_s = peak_abs_r;
      step_ovf_next_s = step_ovf_r;
    end

    if (start_go_s) begin
      overflow_flag_next_s = 1'b0;
    end else if (enter_report_s) begin
      overflow_flag_next_s = overflow_flag_r | ovf_upd_s;
    end else begin
      overflow_flag_next_s = overflow_flag_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amplitude_r     <= {DATA_WIDTH{1'b0}};
      filt_flush_r    <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      peak_valid_r    <= 1'b0;
      step_idx_r      <= 8'd0;
      peak_abs_r      <= {OUT_WIDTH{1'b0}};
      step_ovf_r      <= 1'b0;
      overflow_flag_r <= 1'b0;
    end else begin
      amplitude_r     <= amplitude_next_s;
      filt_flush_r    <= filt_flush_next_s;
      busy_r          <= busy_next_s;
      done_r          <= done_next_s;
      peak_valid_r    <= peak_valid_next_s;
      step_idx_r      <= step_idx_next_s;
      peak_abs_r      <= peak_abs_next_s;
      step_ovf_r      <= step_ovf_next_s;
      overflow_flag_r <= overflow_flag_next_s;
    end
  end

  // Flush/strobe counters and the in-step peak accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_r  <= 2'd0;
      sample_cnt_r <= {CNT_W{1'b0}};
      peak_acc_r   <= {OUT_WIDTH{1'b0}};
      ovf_acc_r    <= 1'b0;
    end else begin
      if (state_next_s != state_r) begin
        flush_cnt_r  <= 2'd0;
        sample_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_FLUSH) begin
        flush_cnt_r  <= flush_cnt_r + 2'd1;
        sample_cnt_r <= {CNT_W{1'b0}};
      end else if (((state_r == ST_SETTLE) || (state_r == ST_MEASURE)) && sample_en) begin
        flush_cnt_r  <= 2'd0;
        sample_cnt_r <= sample_cnt_r + CNT_W'(1'b1);
      end else begin
        flush_cnt_r  <= 2'd0;
        sample_cnt_r <= sample_cnt_r;
      end

      if (state_r == ST_SETTLE) begin
        peak_acc_r <= {OUT_WIDTH{1'b0}};
        ovf_acc_r  <= 1'b0;
      end else if (state_r == ST_MEASURE) begin
        peak_acc_r <= peak_upd_s;
        ovf_acc_r  <= ovf_upd_s;
      end else begin
        peak_acc_r <= peak_acc_r;
        ovf_acc_r  <= ovf_acc_r;
      end
    end
  end

  assign amplitude     = amplitude_r;
  assign filt_flush    = filt_flush_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign peak_valid    = peak_valid_r;
  assign step_idx      = step_idx_r;
  assign peak_abs      = peak_abs_r;
  assign step_ovf      = step_ovf_r;
  assign overflow_flag = overflow_flag_r;

endmodule

// File: tb/tb_dynamic_range_sequencer.sv
// Bench for dynamic_range_sequencer: directed scenarios with randomized data and strobes,
// compared every cycle against a step-level reference model built from the sweep rules.
`timescale 1ns/1ps
module tb_dynamic_range_sequencer;
  localparam int STEPS   = 4;
  localparam int SETTLE  = 8;
  localparam int MEASURE = 16;
  localparam int MAXC    = 512;
  localparam int STEP    = 65535 / STEPS;
  localparam logic [31:0] THRESH = 32'h3FFFFFFF;
`ifdef DRS_OVF_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        flush;
    logic        done;
    logic        pv;
    logic        ovf;
    logic        oflag;
    logic [7:0]  idx;
    logic [15:0] amp;
    logic [31:0] peak;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, abort, sample_en;
  logic signed [31:0] data_out;
  logic [15:0] amplitude;
  logic filt_flush, busy, done, peak_valid, step_ovf, overflow_flag;
  logic [7:0] step_idx;
  logic [31:0] peak_abs;
  obs_t obs;

  dynamic_range_sequencer #(
    .DATA_WIDTH(16), .OUT_WIDTH(32), .AMPLITUDE_STEPS(STEPS), .AMP_MAX(65535),
    .SETTLE_SAMPLES(SETTLE), .MEASURE_SAMPLES(MEASURE), .OVF_THRESH(32'h3FFFFFFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_en(sample_en),
    .data_out(data_out), .amplitude(amplitude), .filt_flush(filt_flush), .busy(busy),
    .done(done), .peak_valid(peak_valid), .step_idx(step_idx), .peak_abs(peak_abs),
    .step_ovf(step_ovf), .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  assign obs = {busy, filt_flush, done, peak_valid, step_ovf, overflow_flag, step_idx, amplitude, peak_abs};

  obs_t        exp_a [MAXC];
  bit          se_a [MAXC];
  bit          start_a [MAXC];
  bit          abort_a [MAXC];
  logic [31:0] drv_a [MAXC];
  int          n_asserts = 0;
  int          n_fails = 0;
  int          end_c;
  int          done_cyc;
  int          pv_cyc [$];
  logic [31:0] pv_peak [$];
  logic [7:0]  pv_idx [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference model: walks the sweep step by step, filling per-cycle expectations and data to drive.
  // mode 0: data = -amplitude of the step; mode 1: random data below the overflow threshold.
  task automatic build(input int mode, input int force_step, input int special_step, input int abort_c);
    int c, k, cnt;
    logic [31:0] v, mag, spk;
    bit sov, special_used, stop;
    obs_t cur;
    for (int i = 0; i < MAXC; i++) begin
      drv_a[i] = $urandom; start_a[i] = 1'b0; abort_a[i] = 1'b0; exp_a[i] = '0;
    end
    start_a[0] = 1'b1;
    cur = '0;
    c = 1; k = 0; stop = 1'b0;
    while (!stop && c < MAXC - 8) begin
      cur.busy = 1'b1; cur.flush = 1'b1; cur.done = 1'b0; cur.pv = 1'b0;
      cur.amp = 16'd0; cur.idx = 8'(k);
      for (int i = 0; i < 4; i++) begin exp_a[c] = cur; c++; end
      cur.flush = 1'b0; cur.amp = 16'(k * STEP);
      cnt = 0; spk = 32'd0; sov = 1'b0; special_used = 1'b0;
      while (cnt < SETTLE + MEASURE && c < MAXC - 4) begin
        exp_a[c] = cur;
        if (cnt >= SETTLE) begin
          if (mode == 0) begin
            v = -(32'(k * STEP));
          end else begin
            v = $urandom_range(32'h0FFFFFFF, 0);
            if ($urandom_range(15, 0) == 0) v = THRESH;
            if ($urandom_range(1, 0) == 1) v = -v;
          end
          if (k == force_step) v = 32'h40000000;
          if (k == special_step && se_a[c] && !special_used) begin
            v = 32'h80000000; special_used = 1'b1;
          end
          drv_a[c] = v;
          if (se_a[c]) begin
            mag = v[31] ? -v : v;
            if (mag > spk) spk = mag;
            if (mag > THRESH) sov = 1'b1;
          end
        end
        if (se_a[c]) cnt++;
        c++;
      end
      cur.peak = spk; cur.ovf = sov; cur.oflag = cur.oflag | sov; cur.pv = 1'b1;
      exp_a[c] = cur; c++;
      cur.pv = 1'b0;
      stop = (k == STEPS - 1) || (HALT_EN && sov);
      if (!stop) k++;
    end
    end_c = c;
    cur.busy = 1'b0; cur.amp = 16'd0; cur.done = 1'b1;
    while (c < MAXC) begin exp_a[c] = cur; c++; end
    if (abort_c > 0) begin
      abort_a[abort_c] = 1'b1;
      cur = exp_a[abort_c];
      cur.busy = 1'b0; cur.flush = 1'b0; cur.done = 1'b0; cur.pv = 1'b0; cur.amp = 16'd0;
      for (int i = abort_c + 1; i < MAXC; i++) exp_a[i] = cur;
    end
  endtask

  task automatic run(input string tag, input int ncyc);
    pv_cyc.delete(); pv_peak.delete(); pv_idx.delete();
    done_cyc = -1;
    for (int c = 0; c <= ncyc && c < MAXC; c++) begin
      @(negedge clk);
      n_asserts++;
      assert (obs === exp_a[c]) else begin
        n_fails++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp_a[c]);
      end
      if (peak_valid === 1'b1) begin
        pv_cyc.push_back(c); pv_peak.push_back(peak_abs); pv_idx.push_back(step_idx);
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      start = start_a[c]; abort = abort_a[c]; sample_en = se_a[c]; data_out = drv_a[c];
    end
    start = 1'b0; abort = 1'b0; sample_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0; sample_en = 1'b0; data_out = 32'sd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_pvc [4];
    logic [31:0] exp_pk [4];
    exp_pvc = '{29, 58, 87, 116};
    exp_pk  = '{32'd0, 32'd16383, 32'd32766, 32'd49149};

    // Reset held with random inputs, then released with start low
    rst = 1'b0; start = 1'b0; abort = 1'b0; sample_en = 1'b0; data_out = 32'sd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("reset_hold", 64'(obs), 64'd0);
      start = 1'($urandom); abort = 1'($urandom); sample_en = 1'($urandom); data_out = $urandom;
    end
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("reset_idle", 64'(obs), 64'd0);
      abort = 1'($urandom); sample_en = 1'($urandom); data_out = $urandom;
    end

    // Full sweep, data = -amplitude, start pulses while busy ignored
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = 1'b1;
    build(0, -1, -1, 0);
    start_a[10] = 1'b1; start_a[45] = 1'b1; start_a[100] = 1'b1;
    run("sweep", end_c + 3);
    check_val("sweep_pv_count", 64'(pv_cyc.size()), 64'd4);
    for (int i = 0; i < 4 && i < pv_cyc.size(); i++) begin
      check_val("sweep_pv_cycle", 64'(pv_cyc[i]), 64'(exp_pvc[i]));
      check_val("sweep_peak", 64'(pv_peak[i]), 64'(exp_pk[i]));
      check_val("sweep_idx", 64'(pv_idx[i]), 64'(i));
    end
    check_val("sweep_done_cycle", 64'(done_cyc), 64'd117);

    // Extremes: one most-negative sample in step 2, random strobes and data
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = ($urandom_range(3, 0) != 0);
    build(1, -1, 2, 0);
    run("extreme", end_c + 3);
    check_val("extreme_peak", 64'(pv_peak.size() > 2 ? pv_peak[2] : 32'd0), 64'h80000000);
    check_val("extreme_flag_done", 64'({overflow_flag, done}), 64'd3);

    // Overflow forced in step 1
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = 1'b1;
    build(0, 1, -1, 0);
    run("ovf_step1", end_c + 3);
    check_val("ovf_report_count", 64'(pv_cyc.size()), HALT_EN ? 64'd2 : 64'd4);
    check_val("ovf_final_idx", 64'(step_idx), HALT_EN ? 64'd1 : 64'd3);
    check_val("ovf_flag", 64'(overflow_flag), 64'd1);

    // Strobe every third cycle
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = ((i % 3) == 1);
    build(1, -1, -1, 0);
    run("gated", end_c + 3);
    check_val("gated_first_report", 64'(pv_cyc.size() > 0 ? pv_cyc[0] : 0), 64'd77);

    // Abort mid-MEASURE of step 1, then simultaneous start+abort in IDLE
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = 1'b1;
    build(1, -1, -1, 48);
    run("abort", 60);
    check_val("abort_reports", 64'(pv_cyc.size()), 64'd1);
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("start_abort_idle", 64'({busy, filt_flush, done, amplitude}), 64'd0);
      @(negedge clk);
    end

    // Reset asserted mid-sweep clears outputs immediately
    do_reset();
    for (int i = 0; i < MAXC; i++) se_a[i] = 1'b1;
    build(0, -1, -1, 0);
    run("pre_reset", 40);
    rst = 1'b0;
    #1;
    check_val("reset_mid_sweep", 64'(obs), 64'd0);
    #1;
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
